// File: rtl/sparse_pkg.sv
// Shared constants for the sparse vector format used by sparse_encoder and conversion.
// A slot is {index zero-extended to 8 bits, value}; a zero value marks an empty slot.
package sparse_pkg;

  localparam int unsigned ELEM_W = 8;
  localparam int unsigned N_ELEM = 16;
  localparam int unsigned N_SLOT = 8;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned SLOT_W = 16;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StScan = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

endpackage

// File: rtl/sparse_encoder.sv
// Dense-to-sparse compressor: scans one captured matrix row an element per cycle and packs
// up to N_SLOT nonzero (index, value) pairs into the sparse vector format.
module sparse_encoder #(
  parameter int unsigned ELEM_W = sparse_pkg::ELEM_W,
  parameter int unsigned N_ELEM = sparse_pkg::N_ELEM,
  parameter int unsigned N_SLOT = sparse_pkg::N_SLOT
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [N_ELEM*ELEM_W-1:0]              Matrix,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [N_SLOT*sparse_pkg::SLOT_W-1:0]  Vector,
  output logic [$clog2(N_ELEM+1)-1:0]           nnz,
  output logic                                  overflow
);
  import sparse_pkg::*;

  localparam int unsigned IdxW = $clog2(N_ELEM);
  localparam int unsigned CntW = $clog2(N_SLOT + 1);
  localparam int unsigned NnzW = $clog2(N_ELEM + 1);
  localparam int unsigned PadW = SLOT_W - IdxW - ELEM_W;

  logic [1:0]                 state_q, state_d;
  logic [N_ELEM*ELEM_W-1:0]   mat_q, mat_d;
  logic [N_SLOT*SLOT_W-1:0]   vec_q, vec_d;
  logic [NnzW-1:0]            nnz_q, nnz_d;
  logic                       ovf_q, ovf_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic [IdxW-1:0]            ptr_q, ptr_d;

  logic [ELEM_W-1:0]          elem;
  logic [SLOT_W-1:0]          slot;
  logic                       nonzero;
  logic                       last;
  logic                       slot_free;

  always_comb begin
    elem = '0;
    for (int i = 0; i < N_ELEM; i++) begin
      if (ptr_q == IdxW'(i)) begin
        elem = mat_q[i*ELEM_W +: ELEM_W];
      end
    end
  end

  assign slot      = {{PadW{1'b0}}, ptr_q, elem};
  assign nonzero   = |elem;
  assign last      = (ptr_q == IdxW'(N_ELEM - 1));
  assign slot_free = (cnt_q < CntW'(N_SLOT));

  always_comb begin
    state_d = state_q;
    mat_d   = mat_q;
    vec_d   = vec_q;
    nnz_d   = nnz_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          mat_d   = Matrix;
          vec_d   = '0;
          nnz_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          ptr_d   = '0;
          state_d = StScan;
        end
      end
      StScan: begin
        if (nonzero) begin
          nnz_d = nnz_q + 1'b1;
          if (slot_free) begin
            for (int k = 0; k < N_SLOT; k++) begin
              if (cnt_q == CntW'(k)) begin
                vec_d[k*SLOT_W +: SLOT_W] = slot;
              end
            end
            cnt_d = cnt_q + 1'b1;
          end else begin
            // Excess nonzeros are still counted in nnz but their slots are dropped.
            ovf_d = 1'b1;
          end
        end
        if (last) begin
          state_d = StDone;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      mat_q   <= '0;
      vec_q   <= '0;
      nnz_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      mat_q   <= mat_d;
      vec_q   <= vec_d;
      nnz_q   <= nnz_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign Vector    = vec_q;
  assign nnz       = nnz_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_sparse_encoder.sv
// Directed bench for sparse_encoder: hand-computed vectors, latency, backpressure and reset.
module tb_sparse_encoder;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] Matrix;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] Vector;
  logic [4:0]   nnz;
  logic         overflow;

  int errors = 0;
  int checks = 0;

  sparse_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Matrix    (Matrix),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Vector    (Vector),
    .nnz       (nnz),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic [127:0] vec, input logic [4:0] n,
                         input logic ovf);
    chk({tag, "_vec"}, Vector, vec);
    chk({tag, "_nnz"}, 128'(nnz), 128'(n));
    chk({tag, "_ovf"}, 128'(overflow), 128'(ovf));
  endtask

  // Called at a negedge while idle; returns at the negedge after the accept edge.
  task automatic start(input logic [127:0] m);
    in_valid = 1'b1;
    Matrix   = m;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic finish_scan(input string tag);
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i == 8) chk({tag, "_busy"}, 128'(in_ready), 128'(0));
    end
    chk({tag, "_lat_pre"}, 128'(out_valid), 128'(0));
    tick();
    chk({tag, "_lat"}, 128'(out_valid), 128'(1));
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_rdy"}, 128'(in_ready), 128'(1));
    chk({tag, "_ov0"}, 128'(out_valid), 128'(0));
  endtask

  logic [127:0] m_two, m_ones, m_a, m_b, m_nine;
  logic [127:0] e_two, e_ones, e_a, e_b, e_nine;
  int n;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    Matrix    = '0;

    m_two = '0;
    m_two[3*8 +: 8]  = 8'h05;
    m_two[10*8 +: 8] = 8'hFF;
    e_two = {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0AFF, 16'h0305};
    m_ones = {16{8'h01}};
    e_ones = {16'h0701, 16'h0601, 16'h0501, 16'h0401, 16'h0301, 16'h0201, 16'h0101, 16'h0001};
    m_a = '0;
    m_a[0 +: 8]    = 8'h80;
    m_a[15*8 +: 8] = 8'h01;
    e_a = {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0F01, 16'h0080};
    m_b = '0;
    for (int k = 0; k < 8; k++) m_b[(2*k+1)*8 +: 8] = 8'h10 + 8'(k);
    e_b = {16'h0F17, 16'h0D16, 16'h0B15, 16'h0914, 16'h0713, 16'h0512, 16'h0311, 16'h0110};
    m_nine = '0;
    for (int k = 0; k < 9; k++) m_nine[k*8 +: 8] = 8'hA0 + 8'(k);
    e_nine = {16'h07A7, 16'h06A6, 16'h05A5, 16'h04A4, 16'h03A3, 16'h02A2, 16'h01A1, 16'h00A0};

    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk_out("rst", '0, 5'd0, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    // All-zero matrix; out_ready held high during the scan must be ignored.
    out_ready = 1'b1;
    start('0);
    chk("zero_accept", 128'(in_ready), 128'(0));
    finish_scan("zero");
    chk_out("zero", '0, 5'd0, 1'b0);
    release_out("zero");

    start(m_two);
    finish_scan("two");
    chk_out("two", e_two, 5'd2, 1'b0);
    release_out("two");

    start(m_ones);
    finish_scan("ones");
    chk_out("ones", e_ones, 5'd16, 1'b1);
    release_out("ones");

    start(m_b);
    finish_scan("eight");
    chk_out("eight", e_b, 5'd8, 1'b0);
    release_out("eight");

    start(m_nine);
    finish_scan("nine");
    chk_out("nine", e_nine, 5'd9, 1'b1);
    release_out("nine");

    // Backpressure: new matrix offered while DONE must wait for the output handshake.
    start(m_a);
    finish_scan("bp_a");
    chk_out("bp_a", e_a, 5'd2, 1'b0);
    in_valid = 1'b1;
    Matrix   = m_b;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", 128'(out_valid), 128'(1));
      chk("bp_hold_ready", 128'(in_ready), 128'(0));
      chk("bp_hold_vec", Vector, e_a);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_idle_ready", 128'(in_ready), 128'(1));
    chk("bp_idle_valid", 128'(out_valid), 128'(0));
    tick();
    chk("bp_accept", 128'(in_ready), 128'(0));
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("bp_lat", 128'(n), 128'(16));
    chk_out("bp_b", e_b, 5'd8, 1'b0);
    n = 0;
    do begin
      tick();
      n++;
    end while (out_valid !== 1'b1 && n < 40);
    chk("b2b_period", 128'(n), 128'(18));
    chk_out("b2b_b", e_b, 5'd8, 1'b0);
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("b2b_idle", 128'(in_ready), 128'(1));

    // Reset asserted in the middle of a scan, then a handshake while reset is high.
    start(m_ones);
    repeat (6) tick();
    chk("mid_nnz6", 128'(nnz), 128'(6));
    tick();
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_ready", 128'(in_ready), 128'(1));
    chk_out("mid_rst", '0, 5'd0, 1'b0);
    in_valid = 1'b1;
    Matrix   = m_two;
    @(negedge clk);
    chk("rst_hs_ready", 128'(in_ready), 128'(1));
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("rst_hs_discard", 128'(in_ready), 128'(1));
    chk("rst_hs_valid", 128'(out_valid), 128'(0));
    start(m_two);
    finish_scan("post_rst");
    chk_out("post_rst", e_two, 5'd2, 1'b0);
    release_out("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
